// File: rtl/food_spawn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// food_spawn_ctrl_pkg
// Shared definitions for the food spawn controller:
//   state_e         - controller state encoding
//   X_W / Y_W       - coordinate widths on the playfield
//   LFSR_TAPS       - feedback tap mask of the 8-bit maximal-length LFSR
//   lfsr8_next()    - one LFSR step: {q[6:0], q[7]^q[3]^q[2]^q[1]}
// -----------------------------------------------------------------------------
package food_spawn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP_X = 2'd1,
    ST_GAP_Y = 2'd2,
    ST_QUERY = 2'd3
  } state_e;

  localparam int X_W = 6;
  localparam int Y_W = 5;

  // Bits 7, 3, 2, 1 feed the XOR that becomes the new LSB.
  localparam logic [7:0] LFSR_TAPS = 8'b1000_1110;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/food_spawn_ctrl_lfsr8_step.sv
// -----------------------------------------------------------------------------
// lfsr8_step
// Free-running 8-bit maximal-length LFSR. Steps every cycle, loads SEED on
// RESET. No enable: player timing is the entropy source.
// Ports:
//   CLK   - clock
//   RESET - synchronous active-high reset (loads SEED)
//   q     - current LFSR value
// -----------------------------------------------------------------------------
module lfsr8_step
  import food_spawn_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = 8'd10
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Next LFSR value.
  always_comb begin
    q_d = lfsr8_next(q_q);
  end

  // LFSR state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/food_spawn_ctrl.sv
// -----------------------------------------------------------------------------
// food_spawn_ctrl
// Places a new food cell: draws x then y from the LFSR (8 steps apart so each
// sample is a fully refreshed byte), rejects out-of-grid values, asks the snake
// body store whether the cell is occupied and retries until a free cell is
// found or MAX_TRIES rejections have happened.
// Ports:
//   CLK, RESET         - clock, synchronous active-high reset
//   spawn_req          - one-cycle request, ignored while busy
//   occ_req/occ_x/occ_y- occupancy query toward the body store
//   occ_ack/occ_hit    - query answer (hit = occupied)
//   food_x/food_y      - committed food position
//   food_valid         - a placed food is held
//   spawn_done         - one-cycle pulse on commit
//   spawn_fail         - one-cycle pulse on retry budget exhaustion
//   busy               - controller not idle
// -----------------------------------------------------------------------------
module food_spawn_ctrl
  import food_spawn_ctrl_pkg::*;
#(
  parameter int         GRID_X    = 40,
  parameter int         GRID_Y    = 30,
  parameter logic [7:0] SEED      = 8'd10,
  parameter int         MAX_TRIES = 64
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           spawn_req,
  output logic           occ_req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  input  logic           occ_ack,
  input  logic           occ_hit,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           food_valid,
  output logic           spawn_done,
  output logic           spawn_fail,
  output logic           busy
);

  logic [7:0]     lfsr_q;
  logic           lfsr_unused_s;

  state_e         state_q;
  logic [2:0]     cnt_q;
  logic [7:0]     tries_q;
  logic [X_W-1:0] cand_x_q;
  logic [Y_W-1:0] cand_y_q;
  logic [X_W-1:0] food_x_q;
  logic [Y_W-1:0] food_y_q;
  logic           food_valid_q;
  logic           done_q;
  logic           fail_q;
  logic           occ_req_q;
  logic           busy_q;

  logic           x_ok_s;
  logic           y_ok_s;
  logic           reject_s;
  logic [7:0]     tries_inc_s;
  logic           last_try_s;

  lfsr8_step #(.SEED(SEED)) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .q     (lfsr_q)
  );

  // Only the low bits are sampled as coordinates.
  assign lfsr_unused_s = ^lfsr_q[7:6];

  // Range checks on the current LFSR sample and the shared rejection decision.
  always_comb begin
    x_ok_s      = ({1'b0, lfsr_q[X_W-1:0]} < 7'(GRID_X));
    y_ok_s      = ({1'b0, lfsr_q[Y_W-1:0]} < 6'(GRID_Y));
    tries_inc_s = tries_q + 8'd1;
    last_try_s  = (tries_inc_s == 8'(MAX_TRIES));
    reject_s    = 1'b0;
    case (state_q)
      ST_GAP_X: reject_s = (cnt_q == 3'd7) && !x_ok_s;
      ST_GAP_Y: reject_s = (cnt_q == 3'd7) && !y_ok_s;
      ST_QUERY: reject_s = occ_ack && occ_hit;
      default:  reject_s = 1'b0;
    endcase
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      tries_q      <= 8'd0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      occ_req_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      // busy lags the return to IDLE by one cycle so a request coinciding
      // with the done/fail pulse is dropped.
      busy_q <= (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (spawn_req && !busy_q) begin
            food_valid_q <= 1'b0;
            tries_q      <= 8'd0;
            cnt_q        <= 3'd0;
            busy_q       <= 1'b1;
            state_q      <= ST_GAP_X;
          end
        end
        ST_GAP_X: begin
          cnt_q <= cnt_q + 3'd1;
          if ((cnt_q == 3'd7) && x_ok_s) begin
            cand_x_q <= lfsr_q[X_W-1:0];
            state_q  <= ST_GAP_Y;
          end
        end
        ST_GAP_Y: begin
          cnt_q <= cnt_q + 3'd1;
          if ((cnt_q == 3'd7) && y_ok_s) begin
            cand_y_q  <= lfsr_q[Y_W-1:0];
            occ_req_q <= 1'b1;
            state_q   <= ST_QUERY;
          end
        end
        ST_QUERY: begin
          if (occ_ack) begin
            occ_req_q <= 1'b0;
            if (!occ_hit) begin
              food_x_q     <= cand_x_q;
              food_y_q     <= cand_y_q;
              food_valid_q <= 1'b1;
              done_q       <= 1'b1;
              state_q      <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // Any rejection restarts the draw, or gives up when the budget is spent.
      if (reject_s) begin
        tries_q <= tries_inc_s;
        cnt_q   <= 3'd0;
        fail_q  <= last_try_s;
        state_q <= last_try_s ? ST_IDLE : ST_GAP_X;
      end
    end
  end

  assign occ_req    = occ_req_q;
  assign occ_x      = cand_x_q;
  assign occ_y      = cand_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign spawn_done = done_q;
  assign spawn_fail = fail_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed bench for food_spawn_ctrl. A second instance with MAX_TRIES=4
// exercises budget exhaustion; both share clock, reset and occupancy answers.
module tb_food_spawn_ctrl;

  localparam int GX = 40;
  localparam int GY = 30;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       spawn_req = 1'b0;
  logic       spawn_req2 = 1'b0;
  logic       occ_ack = 1'b0;
  logic       occ_hit = 1'b0;
  logic       occ_req, occ_req2;
  logic [5:0] occ_x, occ_x2, food_x, food_x2;
  logic [4:0] occ_y, occ_y2, food_y, food_y2;
  logic       food_valid, food_valid2, spawn_done, spawn_done2;
  logic       spawn_fail, spawn_fail2, busy, busy2;

  int errors = 0;
  int checks = 0;
  logic [7:0] m_q;

  always #5 CLK = ~CLK;

  food_spawn_ctrl dut (
    .CLK(CLK), .RESET(RESET), .spawn_req(spawn_req),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .spawn_done(spawn_done), .spawn_fail(spawn_fail), .busy(busy)
  );

  food_spawn_ctrl #(.MAX_TRIES(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .spawn_req(spawn_req2),
    .occ_req(occ_req2), .occ_x(occ_x2), .occ_y(occ_y2),
    .occ_ack(occ_ack), .occ_hit(occ_hit),
    .food_x(food_x2), .food_y(food_y2), .food_valid(food_valid2),
    .spawn_done(spawn_done2), .spawn_fail(spawn_fail2), .busy(busy2)
  );

  function automatic logic [7:0] step8(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[3] ^ q[2] ^ q[1]};
  endfunction

  function automatic logic [7:0] stepn(input logic [7:0] q, input int n);
    logic [7:0] s = q;
    for (int i = 0; i < n; i++) s = step8(s);
    return s;
  endfunction

  // Bench copy of the LFSR, same seed and reset behaviour.
  always @(posedge CLK) m_q <= RESET ? 8'd10 : step8(m_q);

  // Outcome of a spawn with immediate acks; v is the LFSR value in the request
  // cycle, the first nhit queries answer occupied. lat counts cycles from the
  // request cycle to the done/fail pulse.
  function automatic void predict(input logic [7:0] v, input int nhit, input int maxt,
                                  output int lat, output bit fail, output int tries,
                                  output logic [5:0] fx, output logic [4:0] fy,
                                  output logic [5:0] cx0, output logic [4:0] cy0);
    int k = 0;
    int hits = 0;
    int nq = 0;
    logic [7:0] s;
    logic [5:0] x;
    logic [4:0] y;
    lat = 0; fail = 1'b0; tries = 0; fx = 6'd0; fy = 5'd0; cx0 = 6'd0; cy0 = 5'd0;
    for (int g = 0; g < 2000; g++) begin
      k += 8; s = stepn(v, k); x = s[5:0];
      if (int'(x) >= GX) begin
        tries++;
        if (tries == maxt) begin fail = 1'b1; lat = k + 1; return; end
        continue;
      end
      k += 8; s = stepn(v, k); y = s[4:0];
      if (int'(y) >= GY) begin
        tries++;
        if (tries == maxt) begin fail = 1'b1; lat = k + 1; return; end
        continue;
      end
      if (nq == 0) begin cx0 = x; cy0 = y; end
      nq++;
      if (hits < nhit) begin
        hits++; tries++;
        if (tries == maxt) begin fail = 1'b1; lat = k + 2; return; end
        k += 1;
        continue;
      end
      fx = x; fy = y; lat = k + 2;
      return;
    end
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Pulses spawn on one instance with occ_ack held high and runs until a
  // done/fail pulse or a 2000-cycle bound; reports what was observed.
  task automatic run_spawn(input bit which, input int nhit, output logic [7:0] v,
                           output int lat, output bit got_done, output bit got_fail,
                           output int nq, output logic [5:0] qx0, output logic [4:0] qy0,
                           output logic [5:0] qx1, output logic [4:0] qy1);
    v = m_q; lat = 0; got_done = 1'b0; got_fail = 1'b0; nq = 0;
    qx0 = 6'd0; qy0 = 5'd0; qx1 = 6'd0; qy1 = 5'd0;
    if (which) spawn_req2 = 1'b1; else spawn_req = 1'b1;
    tick;
    spawn_req = 1'b0; spawn_req2 = 1'b0;
    for (int j = 1; j <= 2000; j++) begin
      if (which ? spawn_done2 : spawn_done) begin got_done = 1'b1; lat = j; break; end
      if (which ? spawn_fail2 : spawn_fail) begin got_fail = 1'b1; lat = j; break; end
      if (which ? occ_req2 : occ_req) begin
        if (nq == 0) begin qx0 = which ? occ_x2 : occ_x; qy0 = which ? occ_y2 : occ_y; end
        if (nq == 1) begin qx1 = which ? occ_x2 : occ_x; qy1 = which ? occ_y2 : occ_y; end
        occ_hit = (nq < nhit);
        nq++;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick; tick;
    checks++; if ({occ_req, food_valid, spawn_done, spawn_fail, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {occ_req, food_valid, spawn_done, spawn_fail, busy}); end
    checks++; if ({food_x, food_y} !== 11'd0) begin
      errors++; $display("FAIL reset_food got x=%0d y=%0d want 0 0", food_x, food_y); end
    checks++; if ({occ_req2, food_valid2, spawn_done2, spawn_fail2, busy2} !== 5'b0) begin
      errors++; $display("FAIL reset_flags2 got %b want 00000", {occ_req2, food_valid2, spawn_done2, spawn_fail2, busy2}); end
  endtask

  task automatic test_lfsr_sequence;
    logic [7:0] exp_seq [9] = '{8'h0A, 8'h14, 8'h29, 8'h53, 8'hA7, 8'h4F, 8'h9F, 8'h3E, 8'h7D};
    RESET = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (dut.lfsr_q !== exp_seq[i]) begin
        errors++; $display("FAIL lfsr_seq[%0d] got %h want %h", i, dut.lfsr_q, exp_seq[i]); end
      tick;
    end
  endtask

  task automatic test_free_cell;
    logic [7:0] v; int lat, nq, elat, etries; bit gd, gf, ef;
    logic [5:0] qx0, qx1, ex, cx; logic [4:0] qy0, qy1, ey, cy;
    occ_ack = 1'b1; occ_hit = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 3 + 5 * r; w++) tick;
      run_spawn(1'b0, 0, v, lat, gd, gf, nq, qx0, qy0, qx1, qy1);
      predict(v, 0, 64, elat, ef, etries, ex, ey, cx, cy);
      checks++; if (!gd || lat != elat) begin
        errors++; $display("FAIL free_latency[%0d] got done=%0d lat=%0d want done=1 lat=%0d", r, gd, lat, elat); end
      checks++; if (food_x !== ex || food_y !== ey) begin
        errors++; $display("FAIL free_coord[%0d] got %0d,%0d want %0d,%0d", r, food_x, food_y, ex, ey); end
      checks++; if (!(food_x < 6'd40 && food_y < 5'd30) || food_valid !== 1'b1) begin
        errors++; $display("FAIL free_range[%0d] got %0d,%0d valid=%0d want in grid valid=1", r, food_x, food_y, food_valid); end
      tick;
      checks++; if (spawn_done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL free_pulse_end[%0d] got done=%0d busy=%0d want 0 0", r, spawn_done, busy); end
    end
  endtask

  task automatic test_occ_reject;
    logic [7:0] v; int lat, nq, elat, etries; bit gd, gf, ef;
    logic [5:0] qx0, qx1, ex, cx; logic [4:0] qy0, qy1, ey, cy;
    occ_ack = 1'b1;
    tick; tick;
    run_spawn(1'b0, 1, v, lat, gd, gf, nq, qx0, qy0, qx1, qy1);
    occ_hit = 1'b0;
    predict(v, 1, 64, elat, ef, etries, ex, ey, cx, cy);
    checks++; if (!gd || lat != elat || nq != 2) begin
      errors++; $display("FAIL occ_latency got done=%0d lat=%0d q=%0d want 1 %0d 2", gd, lat, nq, elat); end
    checks++; if (qx0 !== cx || qy0 !== cy || qx1 !== ex || qy1 !== ey) begin
      errors++; $display("FAIL occ_candidates got %0d,%0d / %0d,%0d want %0d,%0d / %0d,%0d", qx0, qy0, qx1, qy1, cx, cy, ex, ey); end
    checks++; if (food_x !== ex || food_y !== ey) begin
      errors++; $display("FAIL occ_food got %0d,%0d want %0d,%0d", food_x, food_y, ex, ey); end
    checks++; if (int'(dut.tries_q) != etries) begin
      errors++; $display("FAIL occ_tries got %0d want %0d", dut.tries_q, etries); end
  endtask

  task automatic test_retry_exhaustion;
    logic [7:0] v; int lat, nq, elat, etries; bit gd, gf, ef;
    logic [5:0] qx0, qx1, ex, cx; logic [4:0] qy0, qy1, ey, cy;
    occ_ack = 1'b1;
    tick;
    run_spawn(1'b1, 1000, v, lat, gd, gf, nq, qx0, qy0, qx1, qy1);
    predict(v, 1000, 4, elat, ef, etries, ex, ey, cx, cy);
    checks++; if (!gf || gd || !ef || lat != elat) begin
      errors++; $display("FAIL retry_fail got fail=%0d done=%0d lat=%0d want 1 0 %0d", gf, gd, lat, elat); end
    checks++; if (food_valid2 !== 1'b0 || busy2 !== 1'b1 || food_x2 !== 6'd0) begin
      errors++; $display("FAIL retry_outputs got valid=%0d busy=%0d x=%0d want 0 1 0", food_valid2, busy2, food_x2); end
    tick;
    occ_hit = 1'b0;
    checks++; if (busy2 !== 1'b0 || spawn_fail2 !== 1'b0) begin
      errors++; $display("FAIL retry_after got busy=%0d fail=%0d want 0 0", busy2, spawn_fail2); end
  endtask

  task automatic test_slow_ack_dropped_req;
    logic [7:0] v; int elat, etries, qs; bit ef;
    logic [5:0] ex, cx, hx; logic [4:0] ey, cy, hy;
    occ_ack = 1'b0; occ_hit = 1'b0;
    tick; tick;
    v = m_q;
    spawn_req = 1'b1; tick; spawn_req = 1'b0;
    predict(v, 0, 64, elat, ef, etries, ex, ey, cx, cy);
    qs = 0;
    for (int j = 1; j <= 2000; j++) begin
      if (occ_req) begin qs = j; break; end
      tick;
    end
    checks++; if (qs != elat - 1) begin
      errors++; $display("FAIL slow_query_start got %0d want %0d", qs, elat - 1); end
    hx = occ_x; hy = occ_y;
    checks++; if (hx !== ex || hy !== ey) begin
      errors++; $display("FAIL slow_query_coord got %0d,%0d want %0d,%0d", hx, hy, ex, ey); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (occ_req !== 1'b1 || occ_x !== hx || occ_y !== hy || spawn_done !== 1'b0) begin
        errors++; $display("FAIL slow_stable[%0d] got req=%0d %0d,%0d done=%0d want 1 %0d,%0d 0", i, occ_req, occ_x, occ_y, spawn_done, hx, hy); end
      spawn_req = (i == 2);
      occ_ack = (i == 5);
      tick;
    end
    occ_ack = 1'b0;
    checks++; if (spawn_done !== 1'b1 || occ_req !== 1'b0 || food_x !== ex || food_y !== ey || busy !== 1'b1) begin
      errors++; $display("FAIL slow_done got done=%0d req=%0d food=%0d,%0d busy=%0d want 1 0 %0d,%0d 1", spawn_done, occ_req, food_x, food_y, busy, ex, ey); end
    spawn_req = 1'b1; tick; spawn_req = 1'b0;
    tick;
    checks++; if (busy !== 1'b0 || food_valid !== 1'b1) begin
      errors++; $display("FAIL dropped_req got busy=%0d valid=%0d want 0 1", busy, food_valid); end
  endtask

  task automatic test_reset_mid_query;
    int qs; int pulses;
    occ_ack = 1'b0; occ_hit = 1'b0;
    spawn_req = 1'b1; tick; spawn_req = 1'b0;
    qs = 0;
    for (int j = 1; j <= 2000; j++) begin
      if (occ_req) begin qs = j; break; end
      tick;
    end
    checks++; if (qs == 0) begin
      errors++; $display("FAIL rst_query_reached got no query want query"); end
    tick;
    RESET = 1'b1; tick; RESET = 1'b0;
    checks++; if ({occ_req, food_valid, spawn_done, spawn_fail, busy} !== 5'b0 || {food_x, food_y} !== 11'd0) begin
      errors++; $display("FAIL rst_outputs got flags=%b food=%0d,%0d want 00000 0,0", {occ_req, food_valid, spawn_done, spawn_fail, busy}, food_x, food_y); end
    occ_ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (spawn_done || spawn_fail || occ_req || busy) pulses++;
      tick;
    end
    occ_ack = 1'b0;
    checks++; if (pulses != 0) begin
      errors++; $display("FAIL rst_no_pulse got %0d active cycles want 0", pulses); end
  endtask

  initial begin
    #1;
    test_reset;
    test_lfsr_sequence;
    test_free_cell;
    test_occ_reject;
    test_retry_exhaustion;
    test_slow_ack_dropped_req;
    test_reset_mid_query;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
